// File: rtl/cmp_pkg.sv
// Shared encodings for the iterative set-on-compare unit.
package cmp_pkg;

    localparam logic [1:0] CMP_SLT  = 2'b00;
    localparam logic [1:0] CMP_SLTU = 2'b01;
    localparam logic [1:0] CMP_SEQ  = 2'b10;
    localparam logic [1:0] CMP_SNE  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/cmp_chunk_sub.sv
// One CHUNK-bit slice of A - B computed as a + ~b + cin, with the carry into its MSB exposed.
module cmp_chunk_sub #(
    parameter int unsigned CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK:0] ext;

    always_comb begin
        ext      = {1'b0, a} + {1'b0, ~b} + {{CHUNK{1'b0}}, cin};
        sum      = ext[CHUNK-1:0];
        cout     = ext[CHUNK];
        // Carry into the MSB recovered from the MSB sum bit and its two addends.
        c_msb_in = sum[CHUNK-1] ^ a[CHUNK-1] ^ ~b[CHUNK-1];
    end

endmodule

// File: rtl/slt_iter_cmp.sv
// Multi-cycle set-on-compare (SLT/SLTU/SEQ/SNE) subtracting CHUNK bits per cycle, LSB chunk first.
module slt_iter_cmp
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic [1:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d;

    logic [CHUNK-1:0] sum;
    logic             cout, c_msb_in, zero_fin, flag_v, res;

    cmp_chunk_sub #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a        (a_q[CHUNK-1:0]),
        .b        (b_q[CHUNK-1:0]),
        .cin      (carry_q),
        .sum      (sum),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    always_comb begin
        zero_fin = zero_q & (sum == '0);
        flag_v   = c_msb_in ^ cout;
        case (op_q)
            CMP_SLT:  res = sum[CHUNK-1] ^ flag_v;
            CMP_SLTU: res = ~cout;
            CMP_SEQ:  res = zero_fin;
            default:  res = ~zero_fin;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        r_d     = r_q;
        ovf_d   = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    zero_d  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // Operands shift down so the active chunk always sits in the low bits.
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                carry_d = cout;
                zero_d  = zero_fin;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    r_d     = {{(WIDTH-1){1'b0}}, res};
                    ovf_d   = (op_q == CMP_SLT) & flag_v;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            r_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            r_q     <= r_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign r         = r_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_slt_iter_cmp.sv
// Directed and model-checked bench driving CHUNK=8, 32 and 1 builds with the same operations.
module tb_slt_iter_cmp;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [1:0]  op = '0;

    logic        ir[3];
    logic        ov[3];
    logic        of[3];
    logic [31:0] rr[3];

    int total = 0;
    int bad = 0;
    int lat_exp[3] = '{4, 1, 32};

    always #5 clk = ~clk;

    slt_iter_cmp #(.WIDTH(32), .CHUNK(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b), .op(op),
        .out_valid(ov[0]), .out_ready(out_ready), .r(rr[0]), .ovf(of[0])
    );
    slt_iter_cmp #(.WIDTH(32), .CHUNK(32)) u_dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b), .op(op),
        .out_valid(ov[1]), .out_ready(out_ready), .r(rr[1]), .ovf(of[1])
    );
    slt_iter_cmp #(.WIDTH(32), .CHUNK(1)) u_dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b), .op(op),
        .out_valid(ov[2]), .out_ready(out_ready), .r(rr[2]), .ovf(of[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent reference: {ovf, result bit}.
    function automatic logic [1:0] model(input logic [31:0] x, input logic [31:0] y,
                                         input logic [1:0] o);
        logic [31:0] d;
        logic        v;
        logic        res;
        d = x - y;
        v = (x[31] ^ y[31]) & (d[31] ^ x[31]);
        case (o)
            2'b00:   res = ($signed(x) < $signed(y));
            2'b01:   res = (x < y);
            2'b10:   res = (x == y);
            default: res = (x != y);
        endcase
        return {(o == 2'b00) & v, res};
    endfunction

    task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                          input logic [1:0] opv, input logic [31:0] er, input logic eo);
        bit seen[3];
        seen = '{0, 0, 0};
        @(posedge clk);
        @(negedge clk);
        a = av; b = bv; op = opv; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = ~av; b = $urandom; op = ~opv;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (!seen[i] && ov[i]) begin
                    seen[i] = 1'b1;
                    check($sformatf("%s.%0d.lat", tag, i), k, lat_exp[i]);
                    check($sformatf("%s.%0d.r", tag, i), rr[i], er);
                    check($sformatf("%s.%0d.ovf", tag, i), {31'd0, of[i]}, {31'd0, eo});
                end
            end
            if (seen[0] && seen[1] && seen[2]) break;
        end
        for (int i = 0; i < 3; i++)
            if (!seen[i]) check($sformatf("%s.%0d.timeout", tag, i), 0, 1);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [1:0]  ro, m;
        int          emitted;

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("rst.%0d.in_ready", i), {31'd0, ir[i]}, 1);
            check($sformatf("rst.%0d.out_valid", i), {31'd0, ov[i]}, 0);
            check($sformatf("rst.%0d.r", i), rr[i], 0);
            check($sformatf("rst.%0d.ovf", i), {31'd0, of[i]}, 0);
        end
        @(negedge clk);
        reset = 1'b0;

        run_op("slt_neg",   32'hFFFF_FFFF, 32'h0000_0001, 2'b00, 32'd1, 1'b0);
        run_op("slt_ovf",   32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'd0, 1'b1);
        run_op("sltu",      32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'd1, 1'b0);
        run_op("seq_eq",    32'h0000_1234, 32'h0000_1234, 2'b10, 32'd1, 1'b0);
        run_op("sne_top",   32'h8000_0000, 32'h0000_0000, 2'b11, 32'd1, 1'b0);
        run_op("seq_top",   32'h8000_0000, 32'h0000_0000, 2'b10, 32'd0, 1'b0);
        run_op("sne_eq",    32'hDEAD_BEEF, 32'hDEAD_BEEF, 2'b11, 32'd0, 1'b0);
        run_op("sltu_zero", 32'h0000_0000, 32'h0000_0000, 2'b01, 32'd0, 1'b0);
        run_op("slt_min",   32'h8000_0000, 32'h7FFF_FFFF, 2'b00, 32'd1, 1'b1);
        run_op("sltu_min",  32'h8000_0000, 32'h7FFF_FFFF, 2'b01, 32'd0, 1'b0);

        // Back-pressure: results must hold while out_ready is low.
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        a = 32'hFFFF_FFFF; b = 32'h0000_0001; op = 2'b00; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (34) @(posedge clk);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                check($sformatf("bp%0d.%0d.out_valid", c, i), {31'd0, ov[i]}, 1);
                check($sformatf("bp%0d.%0d.r", c, i), rr[i], 1);
                check($sformatf("bp%0d.%0d.ovf", c, i), {31'd0, of[i]}, 0);
                check($sformatf("bp%0d.%0d.in_ready", c, i), {31'd0, ir[i]}, 0);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("bp_rel.%0d.out_valid", i), {31'd0, ov[i]}, 0);
            check($sformatf("bp_rel.%0d.in_ready", i), {31'd0, ir[i]}, 1);
            check($sformatf("bp_rel.%0d.r", i), rr[i], 1);
        end

        // Reset during the second RUN cycle aborts without emitting.
        @(negedge clk);
        a = 32'h0000_0005; b = 32'h0000_0009; op = 2'b01; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("abort.%0d.out_valid", i), {31'd0, ov[i]}, 0);
            check($sformatf("abort.%0d.r", i), rr[i], 0);
            check($sformatf("abort.%0d.in_ready", i), {31'd0, ir[i]}, 1);
        end
        @(negedge clk);
        reset = 1'b0;
        emitted = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) if (ov[i]) emitted++;
        end
        check("abort.no_emit", emitted, 0);

        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = ($urandom_range(3) == 0) ? ra : 32'($urandom);
            if ($urandom_range(7) == 0) rb = ra ^ 32'h8000_0000;
            ro = 2'($urandom_range(3));
            m  = model(ra, rb, ro);
            run_op($sformatf("rnd%0d", n), ra, rb, ro, {31'd0, m[0]}, m[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
